cook_timer: RTL and testbench
=============================

Name: cook_timer

Overview:
- Countdown timer for the microwave.
- Loads a 4-digit BCD MM:SS cook time from the keypad, shifting digits in from the right.
- Counts down once per second while the magnetron is energised.
- Drives timer_done back to magnetron control, which consumes it to stop heating and to refuse a start at 00:00. Its mag_on output is this block's run enable.

Parameters:
TICKS_PER_SEC, 50_000_000, clk cycles per one-second decrement (benches use 4)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clearn  in  1  clear button, active-low, sampled synchronously
mag_on  in  1  magnetron energised; enables countdown
key_valid  in  1  one-cycle strobe: key_digit is valid
key_digit  in  4  keypad digit, BCD 0..9
min_tens  out  4  BCD display digit
min_ones  out  4  BCD display digit
sec_tens  out  4  BCD display digit
sec_ones  out  4  BCD display digit
timer_done  out  1  level: high when stored time is 00:00
done_pulse  out  1  one-cycle pulse when countdown reaches 00:00 from RUNNING

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - all digits 0
  - timer_done=1, done_pulse=0
  - state ZERO, prescaler 0
- States:
  - ZERO: time is 00:00.
  - LOADED: time nonzero, not counting.
  - RUNNING: time nonzero and mag_on=1.
- Priority per cycle, highest first: clear, tick decrement, key load.
- Clear (clearn=0):
  - All digits 0 next edge, prescaler 0, state ZERO, done_pulse stays 0.
  - Applies in any state, including RUNNING.
- Key load:
  - Accepted only in ZERO or LOADED, when key_valid=1, key_digit<=9 and clearn=1.
  - Shift: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit. Old min_tens is discarded.
  - Digits 10..15 are ignored.
  - Keys are ignored in RUNNING.
  - A loaded 0 into 00:00 keeps state ZERO.
  - Seconds digits may hold values above 59 (e.g. 00:99); no normalisation on load.
- State transitions:
  - ZERO to LOADED when the result of a load is nonzero.
  - LOADED to RUNNING when mag_on=1 and time is nonzero.
  - RUNNING to LOADED when mag_on falls (pause; time retained).
  - ZERO stays ZERO regardless of mag_on.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in RUNNING.
  - Cleared whenever not RUNNING, so each run or resume waits a full TICKS_PER_SEC cycles before the first decrement.
  - Tick = prescaler at TICKS_PER_SEC-1 while in RUNNING.
- Decrement on tick, BCD with borrow:
  - sec_ones>0: sec_ones-1.
  - Else if sec_tens>0: sec_tens-1, sec_ones=9.
  - Else if minutes nonzero: seconds=59, minutes decremented as a 2-digit BCD (ones borrow from tens, ones=9).
  - So 01:00 goes to 00:59, 10:00 goes to 09:59, and 00:99 counts 99..00.
- Reaching zero:
  - When a decrement yields 00:00: state ZERO, timer_done=1 on the same edge, done_pulse=1 for exactly that cycle.
- timer_done:
  - Registered; equals (all digits == 0) after every update.
  - Deasserts on the edge that loads a nonzero digit.
- mag_on held high at zero: no wrap to 99:59; remains 00:00.
- Reset mid-count: immediate return to reset values, no done_pulse.

Decomposition:
- Shared package:
  - state encoding (ZERO, LOADED, RUNNING)
  - BCD digit width 4
  - constant BCD_MAX_SEC_TENS=5
- One natural sub-module: tick_prescaler.
  - Parameter TICKS_PER_SEC.
  - Inputs clk, rst, run; output tick.
  - Counter cleared when run=0.
- The digit/borrow logic and state machine stay in cook_timer.

Test Plan (TICKS_PER_SEC=4):
1. Reset, then keys 1,3,0 with mag_on=0 -> digits 01:30 after third strobe; timer_done=0 from first nonzero load; no decrement.
2. Load 01:00, mag_on=1 -> 00:59 exactly 4 cycles after RUNNING entry, 00:58 4 cycles later; keys pressed meanwhile are ignored.
3. Load 00:02, mag_on=1 -> 00:01, then 00:00 with timer_done=1 and done_pulse=1 for one cycle; with mag_on held, digits stay 00:00 and no further pulse.
4. Load 00:05, run 6 cycles (one tick -> 00:04), drop mag_on for 10 cycles, reassert -> time frozen at 00:04 while paused; next decrement 4 cycles after resume.
5. Load 10:00 and run 1 tick -> 09:59. Separately, load 00:99 and run -> 00:98. Key 0xC -> no change.
6. Load 02:00, run, then clearn=0 for 1 cycle mid-count -> 00:00, timer_done=1, done_pulse=0. Also assert rst mid-count -> outputs take reset values without waiting for clk.

Source files
------------

// File: rtl/cook_timer_pkg.sv
// Shared types and helpers for the microwave cook timer.
//   state_t     : ZERO / LOADED / RUNNING
//   bcd_time_t  : MM:SS as four packed BCD digits, min_tens in the MSBs
//   bcd_shift   : keypad entry, shifts a new digit in from the right
//   bcd_dec     : one-second BCD decrement with borrow
//   time_is_zero: 00:00 detect
package cook_timer_pkg;

    localparam int BCD_W            = 4;
    localparam int BCD_MAX_SEC_TENS = 5;
    localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        ZERO    = 2'd0,
        LOADED  = 2'd1,
        RUNNING = 2'd2
    } state_t;

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } bcd_time_t;

    function automatic logic time_is_zero(input bcd_time_t t);
        return (t == '0);
    endfunction

    // Oldest digit (min_tens) falls off the left end.
    function automatic bcd_time_t bcd_shift(input bcd_time_t t, input logic [BCD_W-1:0] d);
        bcd_time_t r;
        r.min_tens = t.min_ones;
        r.min_ones = t.sec_tens;
        r.sec_tens = t.sec_ones;
        r.sec_ones = d;
        return r;
    endfunction

    // Seconds are decremented as written, so a keyed-in 00:99 counts
    // 99..00; only a minute borrow snaps the seconds to 59.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.sec_ones != '0) begin
            r.sec_ones = t.sec_ones - 1'b1;
        end else if (t.sec_tens != '0) begin
            r.sec_tens = t.sec_tens - 1'b1;
            r.sec_ones = BCD_NINE;
        end else if ((t.min_tens != '0) || (t.min_ones != '0)) begin
            r.sec_tens = BCD_W'(BCD_MAX_SEC_TENS);
            r.sec_ones = BCD_NINE;
            if (t.min_ones != '0) begin
                r.min_ones = t.min_ones - 1'b1;
            end else begin
                r.min_tens = t.min_tens - 1'b1;
                r.min_ones = BCD_NINE;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cook_timer_prescaler.sv
// tick_prescaler: divides clk down to a one-second tick.
//   clk, rst : clock, async active-high reset
//   run      : count enable; the counter is held at 0 while low so every
//              run/resume waits a full TICKS_PER_SEC cycles
//   tick     : high for the last cycle of each second while run=1
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cook_timer.sv
// cook_timer: MM:SS countdown for the microwave.
//   clk, rst        : clock, async active-high reset
//   clearn          : clear button, active-low, synchronous
//   mag_on          : magnetron energised, enables counting
//   key_valid/digit : keypad strobe and BCD digit (10..15 ignored)
//   min_tens..sec_ones : display digits
//   timer_done      : registered, high while the stored time is 00:00
//   done_pulse      : one cycle when a countdown reaches 00:00
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clearn,
    input  logic             mag_on,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_digit,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             timer_done,
    output logic             done_pulse
);

    state_t    state, state_nxt;
    bcd_time_t tm, tm_nxt;
    logic      pulse_nxt;
    logic      run, tick, key_ok;

    assign run = (state == RUNNING);

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .run (run),
        .tick(tick)
    );

    assign key_ok = key_valid && (key_digit <= BCD_NINE) && (state != RUNNING);

    // Priority: clear, then tick decrement, then key load. A tick only
    // happens in RUNNING, where keys are ignored anyway.
    always_comb begin
        tm_nxt    = tm;
        state_nxt = state;
        pulse_nxt = 1'b0;
        if (!clearn) begin
            tm_nxt    = '0;
            state_nxt = ZERO;
        end else if (tick) begin
            tm_nxt = bcd_dec(tm);
            if (time_is_zero(tm_nxt)) begin
                state_nxt = ZERO;
                pulse_nxt = 1'b1;
            end else if (!mag_on) begin
                state_nxt = LOADED;
            end
        end else begin
            if (key_ok) begin
                tm_nxt = bcd_shift(tm, key_digit);
            end
            case (state)
                ZERO: begin
                    if (!time_is_zero(tm_nxt)) state_nxt = LOADED;
                end
                LOADED: begin
                    // Shifting can push the last nonzero digit out.
                    if (time_is_zero(tm_nxt)) state_nxt = ZERO;
                    else if (mag_on)          state_nxt = RUNNING;
                end
                RUNNING: begin
                    if (!mag_on) state_nxt = LOADED;
                end
                default: state_nxt = ZERO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ZERO;
            tm         <= '0;
            timer_done <= 1'b1;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            tm         <= tm_nxt;
            timer_done <= time_is_zero(tm_nxt);
            done_pulse <= pulse_nxt;
        end
    end

    assign min_tens = tm.min_tens;
    assign min_ones = tm.min_ones;
    assign sec_tens = tm.sec_tens;
    assign sec_ones = tm.sec_ones;

endmodule

// File: tb/tb_cook_timer.sv
module tb_cook_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clearn = 1'b1;
    logic       mag_on = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, done_pulse;

    int errors = 0;
    int checks = 0;

    cook_timer #(.TICKS_PER_SEC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clearn    (clearn),
        .mag_on    (mag_on),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .timer_done(timer_done),
        .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clearn;
        logic        mag_on;
        logic        key_valid;
        logic [3:0]  key_digit;
        logic [15:0] exp_time;   // MMSS as BCD nibbles
        logic        exp_done;
        logic        exp_pulse;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] exp_time;
        logic        exp_done;
        logic        exp_pulse;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic cn, input logic mg, input logic kv,
                                input logic [3:0] kd, input logic [15:0] t, input logic p);
        vec_t v;
        v.clearn    = cn;
        v.mag_on    = mg;
        v.key_valid = kv;
        v.key_digit = kd;
        v.exp_time  = t;
        v.exp_done  = (t == 16'h0000);
        v.exp_pulse = p;
        return v;
    endfunction

    // key press, mag_on low
    task automatic key(input logic [3:0] d, input logic [15:0] t);
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, d, t, 1'b0));
    endtask

    // n idle cycles with a given mag_on level
    task automatic idle(input logic mg, input int n, input logic [15:0] t);
        for (int i = 0; i < n; i++) vecs.push_back(mk(1'b1, mg, 1'b0, 4'd0, t, 1'b0));
    endtask

    task automatic clr();
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0));
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] disp();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Drive at negedge, push the expectation, let the posedge happen,
    // then pop and compare 1 time unit later.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        clearn    = v.clearn;
        mag_on    = v.mag_on;
        key_valid = v.key_valid;
        key_digit = v.key_digit;
        e.idx = idx; e.exp_time = v.exp_time; e.exp_done = v.exp_done; e.exp_pulse = v.exp_pulse;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty at vec %0d", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("time[%0d]", e.idx), disp(), e.exp_time);
            chk($sformatf("done[%0d]", e.idx), {15'd0, timer_done}, {15'd0, e.exp_done});
            chk($sformatf("pulse[%0d]", e.idx), {15'd0, done_pulse}, {15'd0, e.exp_pulse});
        end
    endtask

    initial begin
        // 1: load 01:30 without running, digit overflow, clear beats key
        key(4'd0, 16'h0000);
        key(4'd1, 16'h0001);
        key(4'd3, 16'h0013);
        key(4'd0, 16'h0130);
        idle(1'b0, 3, 16'h0130);
        key(4'd5, 16'h1305);
        key(4'd7, 16'h3057);
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'd7, 16'h0000, 1'b0));
        // 2: 01:00 -> 00:59 -> 00:58, key ignored while running
        key(4'd1, 16'h0001);
        key(4'd0, 16'h0010);
        key(4'd0, 16'h0100);
        idle(1'b1, 1, 16'h0100);
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'd5, 16'h0100, 1'b0));
        idle(1'b1, 2, 16'h0100);
        idle(1'b1, 1, 16'h0059);
        idle(1'b1, 3, 16'h0059);
        idle(1'b1, 1, 16'h0058);
        clr();
        // 3: 00:02 down to 00:00 with one done_pulse, held mag_on stays at 0
        key(4'd2, 16'h0002);
        idle(1'b1, 4, 16'h0002);
        idle(1'b1, 4, 16'h0001);
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1));
        idle(1'b1, 6, 16'h0000);
        idle(1'b0, 1, 16'h0000);
        // 4: pause and resume
        key(4'd5, 16'h0005);
        idle(1'b1, 4, 16'h0005);
        idle(1'b1, 2, 16'h0004);
        idle(1'b0, 10, 16'h0004);
        idle(1'b1, 4, 16'h0004);
        idle(1'b1, 1, 16'h0003);
        clr();
        // 5: minute borrow, 00:99, invalid digit
        key(4'd1, 16'h0001);
        key(4'd0, 16'h0010);
        key(4'd0, 16'h0100);
        key(4'd0, 16'h1000);
        idle(1'b1, 4, 16'h1000);
        idle(1'b1, 1, 16'h0959);
        clr();
        key(4'd9, 16'h0009);
        key(4'd9, 16'h0099);
        idle(1'b1, 4, 16'h0099);
        idle(1'b1, 1, 16'h0098);
        idle(1'b0, 1, 16'h0098);
        key(4'hC, 16'h0098);
        clr();
        // 6: clear mid-count (no pulse), ZERO ignores mag_on
        key(4'd2, 16'h0002);
        key(4'd0, 16'h0020);
        key(4'd0, 16'h0200);
        idle(1'b1, 4, 16'h0200);
        idle(1'b1, 2, 16'h0159);
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0));
        idle(1'b1, 5, 16'h0000);
        idle(1'b0, 1, 16'h0000);
        // lead-in for the async reset sequence
        key(4'd3, 16'h0003);
        idle(1'b1, 4, 16'h0003);
        idle(1'b1, 2, 16'h0002);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_time", disp(), 16'h0000);
        chk("reset_done", {15'd0, timer_done}, 16'd1);
        chk("reset_pulse", {15'd0, done_pulse}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // async reset mid-count, away from any clk edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_time", disp(), 16'h0000);
        chk("async_rst_done", {15'd0, timer_done}, 16'd1);
        chk("async_rst_pulse", {15'd0, done_pulse}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        step(mk(1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0), vecs.size());
        step(mk(1'b1, 1'b0, 1'b1, 4'd4, 16'h0004, 1'b0), vecs.size() + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
